// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-side memory controller. It has a word RAM with byte and
// halfword lanes, plus a small IO block: the LED register, a free-running cycle
// counter and a sticky error status register.
// Reads are purely combinational. Stores commit on the rising edge of CLK.
// Optional feature macro: DATA_MEM_CTRL_CYCCNT_EN. When it is defined, the cycle
// counter at 0xFFFF_0004 exists. When it is undefined, that address reads 0 and
// ignores stores.
`timescale 1ns/1ps
module data_mem_ctrl #(
    parameter int RAM_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  MemoryControl,
    output logic [31:0] ReadDataM,
    output logic [7:0]  LEDs,
    output logic        BusError
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    // IO word addresses (byte address bits [31:2])
    localparam logic [29:0] LED_WA  = 30'(32'hFFFF_0000 >> 2);
    localparam logic [29:0] CNT_WA  = 30'(32'hFFFF_0004 >> 2);
    localparam logic [29:0] STAT_WA = 30'(32'hFFFF_0008 >> 2);

    // ---------------------------------------------------------------------
    // Access decode
    // ---------------------------------------------------------------------
    logic          is_byte, is_half, sgn;
    logic          in_ram, sel_led, sel_cnt, sel_stat, io_region;
    logic          misaligned, unmapped, err;
    logic          st_ok;
    logic [AW-1:0] ram_idx;

    assign is_byte = (MemoryControl[1:0] == 2'b10);
    assign is_half = (MemoryControl[1:0] == 2'b01);
    assign sgn     = MemoryControl[2];

    assign in_ram    = (ALUOutM < RAM_BYTES);
    assign sel_led   = (ALUOutM[31:2] == LED_WA);
    assign sel_cnt   = (ALUOutM[31:2] == CNT_WA);
    assign sel_stat  = (ALUOutM[31:2] == STAT_WA);
    // The 16-byte window at 0xFFFF_0000 accepts only word accesses. This also
    // covers the unused slot at 0xFFFF_000C.
    assign io_region = (ALUOutM[31:4] == 28'hFFFF_000);
    assign ram_idx   = ALUOutM[AW+1:2];

    // The alignment check and the map check are independent. If both fail,
    // both sticky bits are set.
    always_comb begin
        misaligned = 1'b0;
        if (is_half && ALUOutM[0])
            misaligned = 1'b1;
        else if (!is_byte && !is_half && (ALUOutM[1:0] != 2'b00))
            misaligned = 1'b1;
        if (io_region && (is_byte || is_half))
            misaligned = 1'b1;
    end

    assign unmapped = !(in_ram || sel_led || sel_cnt || sel_stat);
    assign err      = misaligned || unmapped;
    assign BusError = err;

    // A store takes effect only when it is legal. The RAM also needs Reset
    // released, because its cells are not on the async reset.
    assign st_ok = MemWriteM && !err;

    // ---------------------------------------------------------------------
    // Data RAM (not reset)
    // ---------------------------------------------------------------------
    logic [31:0] mem_q [RAM_WORDS];
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        ram_we;

    // Lane enables and lane-replicated store data for the access size.
    always_comb begin
        st_be   = 4'b1111;
        st_data = WriteDataM;
        if (is_byte) begin
            st_be   = 4'b0001 << ALUOutM[1:0];
            st_data = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            st_be   = ALUOutM[1] ? 4'b1100 : 4'b0011;
            st_data = {2{WriteDataM[15:0]}};
        end
    end

    assign ram_we = st_ok && in_ram && Reset;

    // Byte-lane RAM write. Only the enabled lanes change.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b])
                    mem_q[ram_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // LED register
    // ---------------------------------------------------------------------
    logic [7:0] led_q, led_d;

    // LED next state: load the low byte on a legal store. Otherwise hold.
    always_comb begin
        led_d = led_q;
        if (st_ok && sel_led)
            led_d = WriteDataM[7:0];
    end

    // LED register with async clear.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) led_q <= 8'h00;
        else        led_q <= led_d;
    end

    assign LEDs = led_q;

    // ---------------------------------------------------------------------
    // Cycle counter (optional)
    // ---------------------------------------------------------------------
    logic [31:0] cnt_rd;

`ifdef DATA_MEM_CTRL_CYCCNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counter next state: a store overrides the increment for that cycle.
    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (st_ok && sel_cnt)
            cnt_d = WriteDataM;
    end

    // Counter register with async clear.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) cnt_q <= 32'h0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_rd = cnt_q;
`else
    // Without the counter, the address stays mapped and reads as zero.
    assign cnt_rd = 32'h0;
`endif

    // ---------------------------------------------------------------------
    // Sticky status: bit0 misaligned, bit1 unmapped, write-1-to-clear
    // ---------------------------------------------------------------------
    logic [1:0] stat_q, stat_d;
    logic [1:0] stat_set, stat_clr;

    assign stat_set = {unmapped, misaligned};
    assign stat_clr = (st_ok && sel_stat) ? WriteDataM[1:0] : 2'b00;

    // Status next state: clear first, then set, so a new error wins.
    always_comb begin
        stat_d = (stat_q & ~stat_clr) | stat_set;
    end

    // Status register with async clear.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) stat_q <= 2'b00;
        else        stat_q <= stat_d;
    end

    // ---------------------------------------------------------------------
    // Combinational read path
    // ---------------------------------------------------------------------
    logic [31:0] rd_word, load_val;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the raw word from the addressed target.
    always_comb begin
        rd_word = 32'h0;
        if (in_ram)        rd_word = mem_q[ram_idx];
        else if (sel_led)  rd_word = {24'h0, led_q};
        else if (sel_cnt)  rd_word = cnt_rd;
        else if (sel_stat) rd_word = {30'h0, stat_q};
    end

    // Extract the lane and extend it. Any error forces zero.
    always_comb begin
        lane_b   = rd_word[7:0];
        lane_h   = ALUOutM[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (ALUOutM[1:0])
            2'b01:   lane_b = rd_word[15:8];
            2'b10:   lane_b = rd_word[23:16];
            2'b11:   lane_b = rd_word[31:24];
            default: lane_b = rd_word[7:0];
        endcase
        if (is_byte)
            load_val = sgn ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
        else if (is_half)
            load_val = sgn ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
        if (err)
            load_val = 32'h0;
    end

    assign ReadDataM = load_val;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl. Each scenario is a task that checks
// its own results. Expected values are worked out by hand from the address
// map and the lane rules.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [2:0]  MemoryControl;
    logic [31:0] ReadDataM;
    logic [7:0]  LEDs;
    logic        BusError;

    int total  = 0;
    int passed = 0;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_CNT  = 32'hFFFF_0004;
    localparam logic [31:0] A_STAT = 32'hFFFF_0008;

    data_mem_ctrl #(.RAM_WORDS(1024)) dut (
        .CLK(CLK), .Reset(Reset), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .MemoryControl(MemoryControl),
        .ReadDataM(ReadDataM), .LEDs(LEDs), .BusError(BusError)
    );

    always #5 CLK = ~CLK;

    // Apply one access. The caller then samples, or ticks to commit.
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] mc);
        MemWriteM = we; ALUOutM = a; WriteDataM = wd; MemoryControl = mc;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        drive(1'b0, A_STAT, 32'h0, 3'b000);
        total++;
        if (LEDs !== 8'h00) $display("FAIL reset_leds got=%h exp=00", LEDs);
        else passed++;
        total++;
        if (ReadDataM !== 32'h0 || BusError !== 1'b0)
            $display("FAIL reset_status got=%h be=%b exp=00000000 be=0", ReadDataM, BusError);
        else passed++;
        tick(); tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_load_ext();
        drive(1'b1, 32'h10, 32'h8899_AABB, 3'b000); tick();
        drive(1'b0, 32'h11, 32'h0, 3'b110);
        total++;
        if (ReadDataM !== 32'hFFFF_FFAA) $display("FAIL lb_sext got=%h exp=ffffffaa", ReadDataM);
        else passed++;
        drive(1'b0, 32'h11, 32'h0, 3'b010);
        total++;
        if (ReadDataM !== 32'h0000_00AA) $display("FAIL lbu got=%h exp=000000aa", ReadDataM);
        else passed++;
        drive(1'b0, 32'h12, 32'h0, 3'b101);
        total++;
        if (ReadDataM !== 32'hFFFF_8899) $display("FAIL lh_sext got=%h exp=ffff8899", ReadDataM);
        else passed++;
        drive(1'b0, 32'h10, 32'h0, 3'b001);
        total++;
        if (ReadDataM !== 32'h0000_AABB) $display("FAIL lhu got=%h exp=0000aabb", ReadDataM);
        else passed++;
        drive(1'b0, 32'h13, 32'h0, 3'b010);
        total++;
        if (ReadDataM !== 32'h0000_0088) $display("FAIL lbu_lane3 got=%h exp=00000088", ReadDataM);
        else passed++;
    endtask

    task automatic test_sub_store();
        drive(1'b1, 32'h10, 32'h1122_3344, 3'b000); tick();
        drive(1'b1, 32'h13, 32'hFFFF_FF5A, 3'b010); tick();
        drive(1'b0, 32'h10, 32'h0, 3'b000);
        total++;
        if (ReadDataM !== 32'h5A22_3344) $display("FAIL sb got=%h exp=5a223344", ReadDataM);
        else passed++;
        drive(1'b1, 32'h10, 32'h1234_BEEF, 3'b001); tick();
        drive(1'b0, 32'h10, 32'h0, 3'b011);
        total++;
        if (ReadDataM !== 32'h5A22_BEEF) $display("FAIL sh got=%h exp=5a22beef", ReadDataM);
        else passed++;
    endtask

    task automatic test_errors();
        drive(1'b0, 32'h21, 32'h0, 3'b001);
        total++;
        if (BusError !== 1'b1 || ReadDataM !== 32'h0)
            $display("FAIL mis_half got=%h be=%b exp=00000000 be=1", ReadDataM, BusError);
        else passed++;
        tick();
        drive(1'b0, A_STAT, 32'h0, 3'b000);
        total++;
        if (ReadDataM !== 32'h1) $display("FAIL stat_mis got=%h exp=00000001", ReadDataM);
        else passed++;
        drive(1'b1, A_STAT, 32'h1, 3'b000); tick();
        drive(1'b0, 32'h0004_0000, 32'h0, 3'b000);
        total++;
        if (BusError !== 1'b1 || ReadDataM !== 32'h0)
            $display("FAIL unmapped got=%h be=%b exp=00000000 be=1", ReadDataM, BusError);
        else passed++;
        tick();
        drive(1'b0, A_STAT, 32'h0, 3'b000);
        total++;
        if (ReadDataM !== 32'h2) $display("FAIL stat_unm got=%h exp=00000002", ReadDataM);
        else passed++;
        // a misaligned store must not touch the word it overlaps
        drive(1'b1, 32'h14, 32'hCAFE_F00D, 3'b000); tick();
        drive(1'b1, 32'h16, 32'hDEAD_BEEF, 3'b000); tick();
        drive(1'b0, 32'h14, 32'h0, 3'b000);
        total++;
        if (ReadDataM !== 32'hCAFE_F00D) $display("FAIL mis_store got=%h exp=cafef00d", ReadDataM);
        else passed++;
        // non-word IO access is misaligned and must not reach the LEDs
        drive(1'b1, A_LED, 32'h77, 3'b010);
        total++;
        if (BusError !== 1'b1) $display("FAIL io_byte be=%b exp=1", BusError);
        else passed++;
        tick();
        total++;
        if (LEDs !== 8'h00) $display("FAIL io_byte_led got=%h exp=00", LEDs);
        else passed++;
        drive(1'b0, A_STAT, 32'h0, 3'b000);
        total++;
        if (ReadDataM !== 32'h3) $display("FAIL stat_both got=%h exp=00000003", ReadDataM);
        else passed++;
        drive(1'b1, A_STAT, 32'h3, 3'b000); tick();
        drive(1'b0, A_STAT, 32'h0, 3'b000);
        total++;
        if (ReadDataM !== 32'h0) $display("FAIL stat_clr got=%h exp=00000000", ReadDataM);
        else passed++;
    endtask

    task automatic test_counter();
        drive(1'b1, A_CNT, 32'hFFFF_FFFE, 3'b000); tick();
        drive(1'b0, A_CNT, 32'h0, 3'b000);
`ifdef DATA_MEM_CTRL_CYCCNT_EN
        total++;
        if (ReadDataM !== 32'hFFFF_FFFE) $display("FAIL cnt_load got=%h exp=fffffffe", ReadDataM);
        else passed++;
        tick();
        total++;
        if (ReadDataM !== 32'hFFFF_FFFF) $display("FAIL cnt_inc got=%h exp=ffffffff", ReadDataM);
        else passed++;
        tick();
        total++;
        if (ReadDataM !== 32'h0) $display("FAIL cnt_wrap got=%h exp=00000000", ReadDataM);
        else passed++;
`else
        total++;
        if (ReadDataM !== 32'h0 || BusError !== 1'b0)
            $display("FAIL cnt_absent got=%h be=%b exp=00000000 be=0", ReadDataM, BusError);
        else passed++;
        tick();
        total++;
        if (ReadDataM !== 32'h0) $display("FAIL cnt_absent2 got=%h exp=00000000", ReadDataM);
        else passed++;
`endif
    endtask

    task automatic test_led_reset();
        drive(1'b1, A_LED, 32'h0000_01C3, 3'b000); tick();
        drive(1'b0, A_LED, 32'h0, 3'b000);
        total++;
        if (LEDs !== 8'hC3) $display("FAIL led_out got=%h exp=c3", LEDs);
        else passed++;
        total++;
        if (ReadDataM !== 32'h0000_00C3) $display("FAIL led_rd got=%h exp=000000c3", ReadDataM);
        else passed++;
        // store in flight when reset drops mid-cycle
        drive(1'b1, A_LED, 32'h0000_00FF, 3'b000);
        Reset = 1'b0;
        #1;
        total++;
        if (LEDs !== 8'h00) $display("FAIL led_async got=%h exp=00", LEDs);
        else passed++;
        tick();
        total++;
        if (LEDs !== 8'h00) $display("FAIL led_held got=%h exp=00", LEDs);
        else passed++;
        // RAM stores are also blocked while reset is low
        drive(1'b1, 32'h10, 32'h0BAD_0BAD, 3'b000); tick();
        Reset = 1'b1;
        drive(1'b0, 32'h10, 32'h0, 3'b000);
        total++;
        if (ReadDataM !== 32'h5A22_BEEF) $display("FAIL ram_kept got=%h exp=5a22beef", ReadDataM);
        else passed++;
    endtask

    initial begin
        Reset = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0; MemoryControl = '0;
        test_reset();
        test_load_ext();
        test_sub_store();
        test_errors();
        test_counter();
        test_led_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
